sort_req_arbiter: RTL and testbench
===================================

Name: sort_req_arbiter

Overview:
- Shares one 8x4-bit sorting engine among NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's operand, holding it stable for the engine's full run. Sequences the engine's start/valid handshake and returns the sorted word with a per-requester done pulse.
- Sits between client blocks and the single sorting engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit before abort (used only with SORT_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request level.
- nums_i  in  32*NUM_REQ  operands; requester k uses bits [32k+31:32k].
- done_o  out  NUM_REQ  one-cycle completion pulse, one-hot.
- result_o  out  32  sorted word; valid while any done_o bit is high.
- err_o  out  1  qualifies done_o: result aborted by timeout.
- busy_o  out  1  high whenever the state is not IDLE.
- eng_rst_o  out  1  active-high synchronous reset to the engine.
- eng_start_o  out  1  engine start pulse.
- eng_nums_o  out  32  operand to the engine, registered.
- eng_valid_i  in  1  engine valid output.
- eng_sorted_i  in  32  engine sorted output.

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is synchronous and active-low.
- Reset (rst_ni=0 at a clk_i edge): state=IDLE, done_o=0, result_o=0, err_o=0, busy_o=0, eng_start_o=0, eng_nums_o=0, rr_ptr=0. eng_rst_o=1 while rst_ni=0 and for the first cycle after release.
- Requester rule: hold req_i and the nums_i slice stable until its done_o pulse. Dropping req_i early is illegal; the block still completes and pulses done_o.
- IDLE: if any req_i bit is high, a round-robin grant picks the first requester at or after rr_ptr. Register eng_nums_o from its slice, record grant id, go to ISSUE.
- ISSUE (1 cycle): eng_start_o=1 for exactly one cycle -> WAIT.
  - The engine clears its valid at the edge where it samples start. Stale valid from the previous job is therefore never seen in WAIT.
- WAIT: eng_nums_o stays held, because the engine reads its operand combinationally over 8 count cycles. On eng_valid_i=1 -> RESP.
- RESP (1 cycle): result_o=eng_sorted_i (registered), done_o[grant]=1, err_o=0, rr_ptr=grant+1 modulo NUM_REQ -> IDLE.
- Latency: request sampled in IDLE to done_o is 2 + engine latency + 1 cycles. Engine latency is 8 count cycles plus 8 insert cycles plus zero-count skips, at most 24.
- Back-to-back: the earliest next grant is the IDLE cycle after RESP, so one idle cycle separates jobs.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 jobs.
- Simultaneous requests: the lowest index at or after rr_ptr wins. rr_ptr advances only on completion.
- eng_valid_i high outside WAIT is ignored.
- Reset mid-job: all state is dropped, no done_o is emitted, and eng_rst_o clears the engine.
- result_o holds its last value between pulses; it is meaningful only while done_o is high.

Optional Feature:
- Macro SORT_TIMEOUT_EN.
- Defined: a WAIT cycle counter (width clog2(TIMEOUT_CYCLES+1)) is cleared on entry to WAIT. At TIMEOUT_CYCLES without eng_valid_i:
  - eng_rst_o=1 for one cycle;
  - enter RESP with result_o=0, err_o=1, done_o[grant]=1.
  - The counter reaching its limit and valid arriving in the same cycle counts as success.
- Undefined: no counter; err_o is tied to 0; WAIT lasts until eng_valid_i.

Decomposition:
- Shared definitions header (alongside the existing def.v):
  - state encodings IDLE/ISSUE/WAIT/RESP, 2-bit;
  - nibble-slice macros reused from def.v;
  - SORT_WORD_W=32.
- Sub-module rr_arbiter: NUM_REQ-wide request vector plus pointer -> one-hot grant and binary index, purely combinational. The pointer update stays in the parent.

Test Plan:
- Single request: req_i=0001, nums_i[31:0]=0x3A1F0C52 -> one done_o=0001 pulse, result_o=0xFCA53210, err_o=0; eng_start_o pulses exactly once.
- Operand stability: during WAIT, change nums_i[31:0] to 0xFFFFFFFF -> eng_nums_o stays 0x3A1F0C52 and the result is unchanged.
- Contention: req_i=1111 held, with distinct operands -> done order 0,1,2,3,0; each result is correct; one idle cycle between ISSUE states.
- All-equal and extremes: operand 0x77777777 -> 0x77777777; operand 0x0000000F -> 0xF0000000; latency within the bound.
- Reset mid-WAIT: drop rst_ni for 1 cycle -> no done_o, eng_rst_o high, busy_o=0. The next request completes correctly.
- SORT_TIMEOUT_EN with eng_valid_i stuck low -> after 64 WAIT cycles: eng_rst_o pulse, done_o pulse with err_o=1, result_o=0. The next requester is then served normally.

Source files
------------

// File: rtl/sort_req_arbiter_pkg.sv
// sort_req_arbiter_pkg: shared state encoding and word width for the sort request arbiter.
package sort_req_arbiter_pkg;
  localparam int SORT_WORD_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
endpackage

// File: rtl/sort_req_arbiter_rr.sv
// sort_req_arbiter_rr: combinational round-robin pick of the first request at or after ptr_i.
module sort_req_arbiter_rr #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sort_req_arbiter.sv
// sort_req_arbiter: shares one 8x4-bit sorting engine among NUM_REQ requesters.
// Optional WAIT-state abort with error reporting is enabled by defining SORT_TIMEOUT_EN.
module sort_req_arbiter
  import sort_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [SORT_WORD_W*NUM_REQ-1:0] nums_i,
  output logic [NUM_REQ-1:0]             done_o,
  output logic [SORT_WORD_W-1:0]         result_o,
  output logic                           err_o,
  output logic                           busy_o,
  output logic                           eng_rst_o,
  output logic                           eng_start_o,
  output logic [SORT_WORD_W-1:0]         eng_nums_o,
  input  logic                           eng_valid_i,
  input  logic [SORT_WORD_W-1:0]         eng_sorted_i
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [SORT_WORD_W-1:0] eng_nums_q, eng_nums_d, result_q, result_d, sel_nums;
  logic eng_rst_q, eng_rst_d;
  sort_req_arbiter_rr #(.N(NUM_REQ)) u_rr (
    .req_i(req_i),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );
  always_comb begin
    sel_nums = '0;
    for (int i = 0; i < NUM_REQ; i++)
      sel_nums = sel_nums | (arb_gnt[i] ? nums_i[i*SORT_WORD_W +: SORT_WORD_W] : '0);
  end
`ifdef SORT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    eng_nums_d = eng_nums_q;
    result_d   = result_q;
    eng_rst_d  = 1'b0;
`ifdef SORT_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (|req_i) begin
        eng_nums_d = sel_nums;
        grant_d    = arb_idx;
        state_d    = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef SORT_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: if (eng_valid_i) begin
        result_d = eng_sorted_i;
        state_d  = RESP;
`ifdef SORT_TIMEOUT_EN
        err_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        result_d  = '0;
        err_d     = 1'b1;
        eng_rst_d = 1'b1;
        state_d   = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
`endif
      end
      default: begin
        rr_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      eng_nums_q <= '0;
      result_q   <= '0;
      eng_rst_q  <= 1'b1;
`ifdef SORT_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      eng_nums_q <= eng_nums_d;
      result_q   <= result_d;
      eng_rst_q  <= eng_rst_d;
`ifdef SORT_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  // Engine reset covers the reset itself plus the first cycle after release.
  assign eng_rst_o   = !rst_ni | eng_rst_q;
  assign eng_start_o = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign eng_nums_o  = eng_nums_q;
  assign result_o    = result_q;
  assign done_o      = (state_q == RESP) ? NUM_REQ'(1) << grant_q : '0;
endmodule

// File: tb/tb_sort_req_arbiter.sv
// tb_sort_req_arbiter: directed table-driven bench with a behavioural sorting engine model.
module tb_sort_req_arbiter;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [3:0] req_i = '0;
  logic [127:0] nums_i = '0;
  logic [3:0] done_o;
  logic [31:0] result_o, eng_nums_o;
  logic err_o, busy_o, eng_rst_o, eng_start_o;
  logic eng_valid_i = 1'b0;
  logic [31:0] eng_sorted_i = '0;
  logic eng_run = 1'b0, eng_stuck = 1'b0;
  int eng_cnt = 0;
  int total = 0, bad = 0;

  sort_req_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .nums_i(nums_i),
    .done_o(done_o), .result_o(result_o), .err_o(err_o), .busy_o(busy_o),
    .eng_rst_o(eng_rst_o), .eng_start_o(eng_start_o), .eng_nums_o(eng_nums_o),
    .eng_valid_i(eng_valid_i), .eng_sorted_i(eng_sorted_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] sort_word(input logic [31:0] w);
    logic [31:0] r = '0;
    for (int v = 15; v >= 0; v--)
      for (int k = 0; k < 8; k++)
        if (w[4*k +: 4] == 4'(v)) r = {r[27:0], 4'(v)};
    return r;
  endfunction

  function automatic int zeros(input logic [31:0] w);
    int z = 0;
    for (int k = 0; k < 8; k++) if (w[4*k +: 4] == 4'd0) z++;
    return z;
  endfunction

  // Engine reads its operand live and clears valid when it samples start.
  always @(posedge clk_i) begin
    if (eng_rst_o) begin
      eng_valid_i <= 1'b0;
      eng_run     <= 1'b0;
    end else if (eng_start_o) begin
      eng_valid_i <= 1'b0;
      eng_run     <= 1'b1;
      eng_cnt     <= 16 + zeros(eng_nums_o);
    end else if (eng_run && !eng_stuck) begin
      if (eng_cnt == 1) begin
        eng_valid_i  <= 1'b1;
        eng_sorted_i <= sort_word(eng_nums_o);
        eng_run      <= 1'b0;
      end else eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_job(output int lat, output int starts, output logic [3:0] d);
    lat = 0;
    starts = 0;
    d = '0;
    while (lat < 100) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (eng_start_o) starts++;
      if (done_o != '0) begin
        d = done_o;
        return;
      end
    end
  endtask

  task automatic wait_start(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      seen = eng_start_o;
    end
  endtask

  typedef struct {
    logic [3:0]   req;
    logic [127:0] nums;
    logic [3:0]   exp_done;
    logic [31:0]  exp_res;
    int           exp_lat;
  } vec_t;

  vec_t tv[9];
  logic [3:0] cont_done[5];
  logic [31:0] cont_res[5];

  initial begin
    int lat, st, waitc, dcnt;
    logic [3:0] d;
    logic seen;
    tv[0] = '{4'b0001, {96'h0, 32'h3A1F0C52}, 4'b0001, 32'hFCA53210, 20};
    tv[1] = '{4'b0010, {64'h0, 32'h77777777, 32'h0}, 4'b0010, 32'h77777777, 19};
    tv[2] = '{4'b0100, {32'h0, 32'h0000000F, 64'h0}, 4'b0100, 32'hF0000000, 26};
    tv[3] = '{4'b1000, {32'h12345678, 96'h0}, 4'b1000, 32'h87654321, 19};
    tv[4] = '{4'b0001, {96'h0, 32'hFEDCBA98}, 4'b0001, 32'hFEDCBA98, 19};
    tv[5] = '{4'b0110, {32'h0, 32'h99999999, 32'h10203040, 32'h0}, 4'b0010, 32'h43210000, 23};
    tv[6] = '{4'b1100, {32'h11111111, 32'h00C00B0A, 64'h0}, 4'b0100, 32'hCBA00000, 24};
    tv[7] = '{4'b1001, {32'h5555AAAA, 64'h0, 32'h22222222}, 4'b1000, 32'hAAAA5555, 19};
    tv[8] = '{4'b0011, {64'h0, 32'h33333333, 32'h01010101}, 4'b0001, 32'h11110000, 23};
    cont_done = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cont_res  = '{32'hFCA53210, 32'h87654321, 32'h77777777, 32'hF0000000, 32'hFCA53210};

    repeat (2) @(negedge clk_i);
    check("rst_eng_rst", 32'(eng_rst_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_start", 32'(eng_start_o), 32'd0);
    check("rst_eng_nums", eng_nums_o, 32'd0);
    rst_ni = 1'b1;
    #1 check("eng_rst_after_release", 32'(eng_rst_o), 32'd1);
    @(negedge clk_i);
    check("eng_rst_cleared", 32'(eng_rst_o), 32'd0);

    for (int i = 0; i < 9; i++) begin
      req_i = tv[i].req;
      nums_i = tv[i].nums;
      run_job(lat, st, d);
      check($sformatf("v%0d_done", i), 32'(d), 32'(tv[i].exp_done));
      check($sformatf("v%0d_result", i), result_o, tv[i].exp_res);
      check($sformatf("v%0d_err", i), 32'(err_o), 32'd0);
      check($sformatf("v%0d_latency", i), lat, tv[i].exp_lat);
      check($sformatf("v%0d_starts", i), st, 32'd1);
      req_i = '0;
      @(negedge clk_i);
    end

    req_i = 4'b0001;
    nums_i = {96'h0, 32'h3A1F0C52};
    wait_start(seen);
    check("stab_start_seen", 32'(seen), 32'd1);
    @(negedge clk_i);
    nums_i[31:0] = 32'hFFFFFFFF;
    #1 check("stab_eng_nums", eng_nums_o, 32'h3A1F0C52);
    run_job(lat, st, d);
    check("stab_done", 32'(d), 32'b0001);
    check("stab_result", result_o, 32'hFCA53210);
    check("stab_eng_nums_end", eng_nums_o, 32'h3A1F0C52);
    req_i = '0;
    @(negedge clk_i);

    req_i = 4'b0001;
    nums_i = {96'h0, 32'h3A1F0C52};
    wait_start(seen);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("midrst_eng_rst", 32'(eng_rst_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    req_i = '0;
    rst_ni = 1'b1;
    dcnt = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (done_o != '0) dcnt++;
    end
    check("midrst_no_done", dcnt, 32'd0);
    check("midrst_idle", 32'(busy_o), 32'd0);
    req_i = 4'b1000;
    nums_i = {32'h12345678, 96'h0};
    run_job(lat, st, d);
    check("postrst_done", 32'(d), 32'b1000);
    check("postrst_result", result_o, 32'h87654321);
    req_i = '0;
    @(negedge clk_i);

    req_i = 4'b1111;
    nums_i = {32'h0000000F, 32'h77777777, 32'h12345678, 32'h3A1F0C52};
    for (int j = 0; j < 5; j++) begin
      run_job(lat, st, d);
      check($sformatf("cont%0d_done", j), 32'(d), 32'(cont_done[j]));
      check($sformatf("cont%0d_result", j), result_o, cont_res[j]);
      check($sformatf("cont%0d_starts", j), st, 32'd1);
      @(negedge clk_i);
      check($sformatf("cont%0d_idle_gap", j), 32'(busy_o), 32'd0);
    end
    req_i = '0;
    @(negedge clk_i);

`ifdef SORT_TIMEOUT_EN
    eng_stuck = 1'b1;
    req_i = 4'b0001;
    nums_i = {96'h0, 32'h3A1F0C52};
    waitc = 0;
    d = '0;
    for (int i = 0; i < 200 && d == '0; i++) begin
      @(negedge clk_i);
      if (done_o != '0) d = done_o;
      else if (busy_o && !eng_start_o) waitc++;
    end
    check("to_done", 32'(d), 32'b0001);
    check("to_err", 32'(err_o), 32'd1);
    check("to_result", result_o, 32'd0);
    check("to_eng_rst", 32'(eng_rst_o), 32'd1);
    check("to_wait_cycles", waitc, 32'd64);
    req_i = '0;
    eng_stuck = 1'b0;
    @(negedge clk_i);
    req_i = 4'b0010;
    nums_i = {64'h0, 32'h77777777, 32'h0};
    run_job(lat, st, d);
    check("to_next_done", 32'(d), 32'b0010);
    check("to_next_err", 32'(err_o), 32'd0);
    check("to_next_result", result_o, 32'h77777777);
    req_i = '0;
    @(negedge clk_i);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
